sys_out_deskew: RTL and testbench

//  Output collector downstream of the triangular systolic array. Array results leave skewed:

---
 rtl/sys_out_deskew.sv | 159 +++++++++++++++
 tb/tb_sys_out_deskew.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_out_deskew.sv
// Output collector for the triangular systolic array: realigns skewed lane samples into rows,
// buffers them in a row FIFO drained over valid/ready, and back-pressures the control unit.
module sys_out_deskew #(
  parameter int N_DIM      = 3,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_DIM-1:0]        lane_valid,
  input  logic [N_DIM*DATA_W-1:0] lane_data,
  output logic                    freeze,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_DIM*DATA_W-1:0] out_data,
  output logic [15:0]             out_row_cnt,
  output logic                    skew_err,
  output logic                    ovf_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = N_DIM * DATA_W;

  if ((FIFO_DEPTH < N_DIM + 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sys_out_deskew: FIFO_DEPTH must be a power of 2 and at least N_DIM+1");
  end

  logic [N_DIM-1:0] al_v_s;
  logic [RW-1:0]    al_d_s;

  // Lane i is delayed by N_DIM-1-i cycles so that all lanes of one row meet at the aligner.
  for (genvar i = 0; i < N_DIM; i++) begin : g_lane
    localparam int L = N_DIM - 1 - i;
    if (L == 0) begin : g_pass
      assign al_v_s[i]                  = lane_valid[i];
      assign al_d_s[i*DATA_W +: DATA_W] = lane_data[i*DATA_W +: DATA_W];
    end else begin : g_dly
      logic [L-1:0]             v_q;
      logic [L-1:0][DATA_W-1:0] d_q;

      // Shift register for this lane's valid and data.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_q <= '0;
          d_q <= '0;
        end else if (flush) begin
          v_q <= '0;
          d_q <= '0;
        end else begin
          v_q[0] <= lane_valid[i];
          d_q[0] <= lane_data[i*DATA_W +: DATA_W];
          for (int k = 1; k < L; k++) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end

      assign al_v_s[i]                  = v_q[L-1];
      assign al_d_s[i*DATA_W +: DATA_W] = d_q[L-1];
    end
  end

  logic [RW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   row_cnt_q, row_cnt_d;
  logic          skew_q, skew_d, ovf_q, ovf_d;
  logic          all_v_s, any_v_s, full_s, pop_s, push_s;

  assign all_v_s = &al_v_s;
  assign any_v_s = |al_v_s;
  assign full_s  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop_s   = out_valid & out_ready;
  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign push_s  = all_v_s & (~full_s | pop_s);

  // Next-state for pointers, occupancy, pop counter and sticky error flags.
  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    row_cnt_d = row_cnt_q;
    skew_d    = skew_q;
    ovf_d     = ovf_q;
    if (flush) begin
      wr_d      = '0;
      rd_d      = '0;
      cnt_d     = '0;
      row_cnt_d = '0;
      skew_d    = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      if (push_s) begin
        wr_d = wr_q + AW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d      = rd_q + AW'(1);
        row_cnt_d = row_cnt_q + 16'd1;
      end else begin
        rd_d      = rd_q;
        row_cnt_d = row_cnt_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (any_v_s && !all_v_s) begin
        skew_d = 1'b1;
      end else begin
        skew_d = skew_q;
      end
      if (all_v_s && full_s && !pop_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // FIFO storage and control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      row_cnt_q <= '0;
      skew_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (flush) begin
        for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
      end else if (push_s) begin
        mem_q[wr_q] <= al_d_s;
      end
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      row_cnt_q <= row_cnt_d;
      skew_q    <= skew_d;
      ovf_q     <= ovf_d;
    end
  end

  // Free slots must cover the rows that may still be in the skew pipeline.
  assign freeze      = ((CW'(FIFO_DEPTH) - cnt_q) <= CW'(N_DIM));
  assign out_valid   = (cnt_q != '0);
  assign out_data    = mem_q[rd_q];
  assign out_row_cnt = row_cnt_q;
  assign skew_err    = skew_q;
  assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_sys_out_deskew.sv
// Self-checking bench for sys_out_deskew: vector table, directed corner sequences and a
// randomized phase checked against a row-level queue model.
module tb_sys_out_deskew;
  localparam int N  = 3;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int RW = N * W;

  logic          clk = 1'b0;
  logic          rst, flush, out_ready;
  logic [N-1:0]  lane_valid;
  logic [RW-1:0] lane_data;
  logic          freeze, out_valid, skew_err, ovf_err;
  logic [RW-1:0] out_data;
  logic [15:0]   out_row_cnt;

  always #5 clk = ~clk;

  sys_out_deskew #(.N_DIM(N), .DATA_W(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .lane_valid(lane_valid), .lane_data(lane_data),
    .freeze(freeze), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_cnt(out_row_cnt), .skew_err(skew_err), .ovf_err(ovf_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a row queue plus a record of the lane inputs of the last N-1 cycles.
  logic [RW-1:0] mq[$];
  int            m_rows;
  bit            m_skew, m_ovf;
  logic [N-1:0]  hv [N-1];
  logic [RW-1:0] hd [N-1];

  function automatic void model_clear();
    mq.delete();
    m_rows = 0;
    m_skew = 1'b0;
    m_ovf  = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      hv[k] = '0;
      hd[k] = '0;
    end
  endfunction

  task automatic compare_model();
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) chk("out_data", out_data, mq[0]);
    chk("freeze", freeze, (D - mq.size()) <= N);
    chk("out_row_cnt", out_row_cnt, m_rows % 65536);
    chk("skew_err", skew_err, m_skew);
    chk("ovf_err", ovf_err, m_ovf);
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic cycle(input logic [N-1:0] lv, input logic [RW-1:0] ld, input logic rdy,
                       input logic fl);
    logic [N-1:0]  av;
    logic [RW-1:0] ad;
    bit            pop;
    int            sz0;
    lane_valid = lv;
    lane_data  = ld;
    out_ready  = rdy;
    flush      = fl;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) begin
        av[i]       = lv[i];
        ad[i*W +: W] = ld[i*W +: W];
      end else begin
        av[i]       = hv[N-2-i][i];
        ad[i*W +: W] = hd[N-2-i][i*W +: W];
      end
    end
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      sz0 = mq.size();
      pop = (sz0 != 0) && rdy;
      if (av != '0 && av != {N{1'b1}}) m_skew = 1'b1;
      if (pop) begin
        void'(mq.pop_front());
        m_rows++;
      end
      if (av == {N{1'b1}}) begin
        if (sz0 == D && !pop) m_ovf = 1'b1;
        else mq.push_back(ad);
      end
      for (int k = N - 2; k > 0; k--) begin
        hv[k] = hv[k-1];
        hd[k] = hd[k-1];
      end
      hv[0] = lv;
      hd[0] = ld;
    end
    #1;
    compare_model();
  endtask

  logic [RW-1:0] rowbuf [16];

  function automatic logic [RW-1:0] mkrow(input int v);
    logic [RW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v + i);
    return r;
  endfunction

  // Inject rows rowbuf[first..first+n-1] with the array's skew: lane i of row r at step r+i.
  // rdy_mode: 0 never ready, 1 always ready, 2 ready only once the last lane is arriving.
  task automatic inject(input int first, input int n, input int rdy_mode, input int mask_row,
                        input logic [N-1:0] mask, input bit flush_last);
    logic [N-1:0]  lv;
    logic [RW-1:0] ld;
    logic          rdy;
    int            r;
    int            last;
    last = n + N - 2;
    for (int s = 0; s <= last; s++) begin
      lv = '0;
      ld = '0;
      for (int i = 0; i < N; i++) begin
        r = s - i;
        if (r >= 0 && r < n && !(r == mask_row && !mask[i])) begin
          lv[i]        = 1'b1;
          ld[i*W +: W] = rowbuf[first + r][i*W +: W];
        end
      end
      rdy = (rdy_mode == 1) || (rdy_mode == 2 && s >= N - 1);
      cycle(lv, ld, rdy, flush_last && (s == last));
    end
  endtask

  typedef struct {
    logic [N-1:0]  lv;
    logic [RW-1:0] ld;
    logic          ev;
    logic [RW-1:0] ed;
    logic [15:0]   ecnt;
  } vec_t;

  vec_t tv [5];

  logic [N-1:0]  sv_v   [N];
  logic [N-1:0]  sv_m   [N];
  logic [RW-1:0] sv_d   [N];

  initial begin
    logic [N-1:0]  lv;
    logic [RW-1:0] ld;
    int            rlevel;

    tv[0] = '{3'b001, {16'd0, 16'd0, 16'd1}, 1'b0, 48'h0, 16'd0};
    tv[1] = '{3'b011, {16'd0, 16'd2, 16'd4}, 1'b0, 48'h0, 16'd0};
    tv[2] = '{3'b110, {16'd3, 16'd5, 16'd0}, 1'b1, 48'h0003_0002_0001, 16'd0};
    tv[3] = '{3'b100, {16'd6, 16'd0, 16'd0}, 1'b1, 48'h0006_0005_0004, 16'd1};
    tv[4] = '{3'b000, {16'd0, 16'd0, 16'd0}, 1'b0, 48'h0, 16'd2};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; lane_valid = '0; lane_data = '0;
    model_clear();
    #1 rst = 1'b0;
    #2;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset freeze", freeze, 1'b0);
    chk("reset out_data", out_data, 48'h0);
    chk("reset out_row_cnt", out_row_cnt, 16'd0);
    chk("reset skew_err", skew_err, 1'b0);
    chk("reset ovf_err", ovf_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Basic deskew of two rows, table-driven.
    for (int k = 0; k < 5; k++) begin
      cycle(tv[k].lv, tv[k].ld, 1'b1, 1'b0);
      chk($sformatf("t1[%0d] out_valid", k), out_valid, tv[k].ev);
      if (tv[k].ev) chk($sformatf("t1[%0d] out_data", k), out_data, tv[k].ed);
      chk($sformatf("t1[%0d] out_row_cnt", k), out_row_cnt, tv[k].ecnt);
      chk($sformatf("t1[%0d] errors", k), {skew_err, ovf_err}, 2'b00);
    end

    // Five rows with consumer stalled, then drain.
    cycle('0, '0, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++) rowbuf[r] = mkrow(100 + 3 * r);
    inject(0, 5, 0, -1, '1, 1'b0);
    chk("t2 freeze at 5", freeze, 1'b1);
    chk("t2 head", out_data, rowbuf[0]);
    cycle('0, '0, 1'b1, 1'b0);
    chk("t2 freeze at 4", freeze, 1'b0);
    for (int r = 1; r < 5; r++) begin
      chk($sformatf("t2 drain %0d", r), out_data, rowbuf[r]);
      cycle('0, '0, 1'b1, 1'b0);
    end
    chk("t2 empty", out_valid, 1'b0);
    chk("t2 row_cnt", out_row_cnt, 16'd5);

    // Row with lane 1 missing is dropped; following row passes.
    cycle('0, '0, 1'b0, 1'b1);
    rowbuf[0] = mkrow(50);
    rowbuf[1] = mkrow(7);
    inject(0, 2, 1, 0, 3'b101, 1'b0);
    chk("t3 skew_err", skew_err, 1'b1);
    chk("t3 valid", out_valid, 1'b1);
    chk("t3 data", out_data, 48'h0009_0008_0007);
    cycle('0, '0, 1'b1, 1'b0);
    chk("t3 row_cnt", out_row_cnt, 16'd1);
    chk("t3 empty", out_valid, 1'b0);

    // Overflow: nine rows into eight slots.
    cycle('0, '0, 1'b0, 1'b1);
    for (int r = 0; r < 9; r++) rowbuf[r] = mkrow(200 + 3 * r);
    inject(0, 9, 0, -1, '1, 1'b0);
    chk("t4 ovf_err", ovf_err, 1'b1);
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("t4 drain %0d", r), out_data, rowbuf[r]);
      cycle('0, '0, 1'b1, 1'b0);
    end
    chk("t4 empty", out_valid, 1'b0);

    // Full FIFO with simultaneous push and pop.
    cycle('0, '0, 1'b0, 1'b1);
    for (int r = 0; r < 9; r++) rowbuf[r] = mkrow(300 + 3 * r);
    inject(0, 8, 0, -1, '1, 1'b0);
    inject(8, 1, 2, -1, '1, 1'b0);
    chk("t5 ovf_err", ovf_err, 1'b0);
    chk("t5 freeze", freeze, 1'b1);
    chk("t5 row_cnt", out_row_cnt, 16'd1);
    for (int r = 1; r < 9; r++) begin
      chk($sformatf("t5 drain %0d", r), out_data, rowbuf[r]);
      cycle('0, '0, 1'b1, 1'b0);
    end
    chk("t5 empty", out_valid, 1'b0);

    // Asynchronous reset mid-stream.
    cycle('0, '0, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++) rowbuf[r] = mkrow(400 + 3 * r);
    inject(0, 2, 1, -1, '1, 1'b0);
    inject(2, 3, 0, 2, 3'b110, 1'b0);
    cycle(3'b011, mkrow(777), 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("t6 rst out_valid", out_valid, 1'b0);
    chk("t6 rst freeze", freeze, 1'b0);
    chk("t6 rst skew_err", skew_err, 1'b0);
    chk("t6 rst ovf_err", ovf_err, 1'b0);
    chk("t6 rst row_cnt", out_row_cnt, 16'd0);
    model_clear();
    lane_valid = '0; lane_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    cycle('0, '0, 1'b1, 1'b0);
    cycle('0, '0, 1'b1, 1'b0);
    chk("t6 no stale rows", out_valid, 1'b0);
    rowbuf[0] = mkrow(500);
    inject(0, 1, 1, -1, '1, 1'b0);
    chk("t6 new row", out_data, rowbuf[0]);
    cycle('0, '0, 1'b1, 1'b0);

    // Same scenario using flush, with an aligned push and a pop in the flush cycle.
    for (int r = 0; r < 9; r++) rowbuf[r] = mkrow(600 + 3 * r);
    inject(0, 6, 0, 2, 3'b011, 1'b0);
    inject(6, 1, 1, -1, '1, 1'b1);
    chk("t6 flush out_valid", out_valid, 1'b0);
    chk("t6 flush freeze", freeze, 1'b0);
    chk("t6 flush errors", {skew_err, ovf_err}, 2'b00);
    chk("t6 flush row_cnt", out_row_cnt, 16'd0);
    cycle('0, '0, 1'b1, 1'b0);
    cycle('0, '0, 1'b1, 1'b0);
    chk("t6 flush no stale", out_valid, 1'b0);

    // Randomized traffic against the model.
    for (int k = 0; k < N; k++) begin
      sv_v[k] = '0; sv_m[k] = '0; sv_d[k] = '0;
    end
    rlevel = 5;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) rlevel = $urandom_range(0, 10);
      for (int k = N - 1; k > 0; k--) begin
        sv_v[k] = sv_v[k-1]; sv_m[k] = sv_m[k-1]; sv_d[k] = sv_d[k-1];
      end
      sv_v[0] = {N{$urandom_range(0, 1) == 1}};
      sv_m[0] = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
      sv_d[0] = {$urandom, $urandom};
      lv = '0;
      ld = '0;
      for (int i = 0; i < N; i++) begin
        lv[i]        = sv_v[i][0] & sv_m[i][i];
        ld[i*W +: W] = sv_d[i][i*W +: W];
      end
      cycle(lv, ld, $urandom_range(0, 9) < rlevel, $urandom_range(0, 149) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
